// File: rtl/lfsr_multi.sv
// lfsr_multi: bank of independent run-time programmable Galois LFSRs with lock-up recovery
module lfsr_multi #(
  parameter int NBITS = 8,
  parameter int NCH = 4,
  parameter int DIVBITS = 16,
  parameter logic [NBITS-1:0] DEF_TAPS = 'h1D,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1,
  localparam int WDW = NBITS > DIVBITS ? NBITS : DIVBITS
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               wr_en,
  input  logic [CHW-1:0]     wr_ch,
  input  logic [1:0]         wr_sel,
  input  logic [WDW-1:0]     wr_data,
  output logic [NCH*NBITS-1:0] lfsr,
  output logic [NCH-1:0]     noise,
  output logic [NCH-1:0]     step,
  output logic [NCH-1:0]     lockup
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [NBITS-1:0] state, taps, seed, nxt, rec;
    logic [DIVBITS-1:0] div, cnt;
    logic inv, en, run, tick, hit, lock, step_r, lock_r;
    assign hit = wr_en && wr_ch == CHW'(c);
    assign run = enable && en;
    assign tick = run && cnt == '0;
    assign nxt = {state[NBITS-2:0], 1'b0} ^ ((state[NBITS-1] ^ inv) ? taps : '0);
    assign lock = nxt == state;
    assign rec = (seed == '0 || seed == state) ? '1 : seed;
    assign lfsr[c*NBITS +: NBITS] = state;
    assign noise[c] = state[NBITS-1];
    assign step[c] = step_r;
    assign lockup[c] = lock_r;
    // divider, register writes and state advance; a seed write beats a same-cycle tick
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= '1;
        taps <= DEF_TAPS;
        seed <= '1;
        div <= '0;
        cnt <= '0;
        inv <= 1'b0;
        en <= 1'b1;
        step_r <= 1'b0;
        lock_r <= 1'b0;
      end else begin
        step_r <= 1'b0;
        lock_r <= 1'b0;
        if (tick) cnt <= div;
        else if (run) cnt <= cnt - 1'b1;
        if (hit && wr_sel == 2'd0) taps <= wr_data[NBITS-1:0];
        if (hit && wr_sel == 2'd2) div <= wr_data[DIVBITS-1:0];
        if (hit && wr_sel == 2'd3) {inv, en} <= wr_data[1:0];
        if (hit && wr_sel == 2'd1) begin
          seed <= wr_data[NBITS-1:0];
          state <= wr_data[NBITS-1:0];
        end else if (tick) begin
          state <= lock ? rec : nxt;
          step_r <= 1'b1;
          lock_r <= lock;
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_multi.sv
// tb_lfsr_multi: directed checks of stepping, divider, lock-up, invert, write priority and async reset
module tb_lfsr_multi;
  logic clk = 0, reset_n = 0, enable = 0, wr_en = 0;
  logic [1:0] wr_ch = 0, wr_sel = 0;
  logic [15:0] wr_data = 0;
  logic [31:0] lfsr;
  logic [3:0] noise, step, lockup;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  lfsr_multi dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_sel(wr_sel), .wr_data(wr_data), .lfsr(lfsr), .noise(noise), .step(step), .lockup(lockup)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] d);
    wr_ch = ch;
    wr_sel = sel;
    wr_data = d;
    wr_en = 1;
    @(negedge clk);
    wr_en = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_lfsr", lfsr, 32'hFFFFFFFF);
    chk("rst_noise", noise, 4'hF);
    chk("rst_step", step, 4'h0);
    chk("rst_lockup", lockup, 4'h0);
    reset_n = 1;
    enable = 1;
    @(negedge clk);
    chk("t1_e3", lfsr, 32'hE3E3E3E3);
    chk("t1_step1", step, 4'hF);
    @(negedge clk);
    chk("t1_db", lfsr, 32'hDBDBDBDB);
    chk("t1_step2", step, 4'hF);
    chk("t1_noise", noise, 4'hF);
    enable = 0;
    wr(0, 2, 16'd3);
    chk("t2_idle_step", step, 4'h0);
    enable = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("t2_step%0d", i), step, (i == 1 || i == 5) ? 4'hF : 4'hE);
    end
    chk("t2_lfsr", lfsr, 32'h3737374B);
    enable = 0;
    wr(0, 2, 16'd0);
    wr(0, 1, 16'h00);
    chk("t3_seed0", lfsr, 32'h37373700);
    chk("t3_wr_step", step, 4'h0);
    wr(1, 3, 16'd0);
    wr(2, 3, 16'd0);
    wr(3, 3, 16'd0);
    enable = 1;
    @(negedge clk);
    chk("t3_recover", lfsr, 32'h373737FF);
    chk("t3_lockup", lockup, 4'h1);
    chk("t3_step", step, 4'h1);
    @(negedge clk);
    chk("t3_next", lfsr, 32'h373737E3);
    chk("t3_lockup_off", lockup, 4'h0);
    chk("t3_step2", step, 4'h1);
    enable = 0;
    wr(0, 1, 16'h00);
    wr(0, 3, 16'd3);
    enable = 1;
    @(negedge clk);
    chk("t4_inv", lfsr, 32'h3737371D);
    chk("t4_lockup", lockup, 4'h0);
    chk("t4_step", step, 4'h1);
    wr(0, 1, 16'h5A);
    chk("t5_seed", lfsr, 32'h3737375A);
    chk("t5_step", step, 4'h0);
    @(negedge clk);
    chk("t5_a9", lfsr, 32'h373737A9);
    chk("t5_step2", step, 4'h1);
    chk("t5_noise", noise, 4'h1);
    enable = 0;
    wr(0, 2, 16'd5);
    enable = 1;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("t6_lfsr", lfsr, 32'hFFFFFFFF);
    chk("t6_noise", noise, 4'hF);
    chk("t6_step", step, 4'h0);
    chk("t6_lockup", lockup, 4'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("t6_restart", lfsr, 32'hE3E3E3E3);
    chk("t6_restart_step", step, 4'hF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
